// File: rtl/ooo_pkg.sv
// rtl/ooo_pkg.sv - shared widths, zero-tag constant and entry records for the OoO issue path
package ooo_pkg;

  localparam int DEF_TAG_W  = 6;
  localparam int DEF_DATA_W = 32;

  // Tag 0 names the hard-wired zero register, which never needs a wakeup.
  localparam logic [DEF_TAG_W-1:0] ZERO_TAG = '0;

  typedef struct packed {
    logic                  rdy;
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_DATA_W-1:0] val;
  } src_t;

  typedef struct packed {
    logic valid;
    src_t a;
    src_t b;
  } entry_t;

endpackage

// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - enqueue, writeback broadcast and issue signals of the issue queue
interface issue_queue_if
  import ooo_pkg::*;
#(
  parameter int TAG_W     = DEF_TAG_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PAYLOAD_W = 128,
  parameter int NUM_WB    = 2
);
  logic                       enq_valid;
  logic                       enq_ready;
  logic [2*TAG_W-1:0]         enq_tag;
  logic [1:0]                 enq_rdy;
  logic [2*DATA_W-1:0]        enq_val;
  logic [PAYLOAD_W-1:0]       enq_payload;
  logic [NUM_WB-1:0]          wb_valid;
  logic [NUM_WB*TAG_W-1:0]    wb_tag;
  logic [NUM_WB*DATA_W-1:0]   wb_data;
  logic                       iss_valid;
  logic                       iss_ready;
  logic [DATA_W-1:0]          iss_opa;
  logic [DATA_W-1:0]          iss_opb;
  logic [PAYLOAD_W-1:0]       iss_payload;

  modport master (
    output enq_valid, enq_tag, enq_rdy, enq_val, enq_payload,
    output wb_valid, wb_tag, wb_data, iss_ready,
    input  enq_ready, iss_valid, iss_opa, iss_opb, iss_payload
  );

  modport slave (
    input  enq_valid, enq_tag, enq_rdy, enq_val, enq_payload,
    input  wb_valid, wb_tag, wb_data, iss_ready,
    output enq_ready, iss_valid, iss_opa, iss_opb, iss_payload
  );

endinterface

// File: rtl/age_select.sv
// rtl/age_select.sv - age matrix with one-hot grant of the oldest requesting entry
module age_select #(
  parameter int DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);

  // older[i][j] set means entry i was allocated before entry j.
  logic [DEPTH-1:0] older [DEPTH];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc[j] && i != j) older[i][j] <= 1'b1;
          else if (alloc[i])      older[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && req[j] && older[j][i]) grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - out-of-order issue queue with tag wakeup, enqueue bypass and oldest-ready select
module issue_queue
  import ooo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PAYLOAD_W = 128,
  parameter int NUM_WB    = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   FLUSH,
  issue_queue_if.slave           io,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]     valid, rdy_a, rdy_b;
  logic [TAG_W-1:0]     tag_a [DEPTH];
  logic [TAG_W-1:0]     tag_b [DEPTH];
  logic [DATA_W-1:0]    val_a [DEPTH];
  logic [DATA_W-1:0]    val_b [DEPTH];
  logic [PAYLOAD_W-1:0] payload [DEPTH];

  logic [DEPTH-1:0]  alloc_oh, alloc, req, grant, wake_a, wake_b;
  logic [DATA_W-1:0] wake_data_a [DEPTH];
  logic [DATA_W-1:0] wake_data_b [DEPTH];
  logic              enq_fire, iss_fire;
  logic              byp_a, byp_b, given_a, given_b, new_rdy_a, new_rdy_b;
  logic [DATA_W-1:0] byp_data_a, byp_data_b, new_val_a, new_val_b;
  logic [TAG_W-1:0]  new_tag_a, new_tag_b;

  // Returns {hit, data}; iterating downwards lets the lowest channel win.
  function automatic logic [DATA_W:0] snoop(
    input logic [TAG_W-1:0]         t,
    input logic [NUM_WB-1:0]        v,
    input logic [NUM_WB*TAG_W-1:0]  tg,
    input logic [NUM_WB*DATA_W-1:0] dt
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int k = NUM_WB - 1; k >= 0; k--) begin
      if (v[k] && tg[k*TAG_W +: TAG_W] == t && t != TAG_W'(ZERO_TAG))
        r = {1'b1, dt[k*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CNT_W'(valid[i]);
  end

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign io.enq_ready = !full && !FLUSH;
  assign enq_fire     = io.enq_valid && io.enq_ready;
  assign req          = valid & rdy_a & rdy_b;
  assign io.iss_valid = (|req) && !FLUSH;
  assign iss_fire     = io.iss_valid && io.iss_ready;

  // Lowest-index slot that is free before the edge; a slot freed by issue is not reused this cycle.
  always_comb begin
    alloc_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
      end
    end
  end

  assign alloc = enq_fire ? alloc_oh : '0;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {wake_a[i], wake_data_a[i]} = snoop(tag_a[i], io.wb_valid, io.wb_tag, io.wb_data);
      {wake_b[i], wake_data_b[i]} = snoop(tag_b[i], io.wb_valid, io.wb_tag, io.wb_data);
    end
  end

  assign new_tag_a = io.enq_tag[TAG_W-1:0];
  assign new_tag_b = io.enq_tag[2*TAG_W-1:TAG_W];
  assign {byp_a, byp_data_a} = snoop(new_tag_a, io.wb_valid, io.wb_tag, io.wb_data);
  assign {byp_b, byp_data_b} = snoop(new_tag_b, io.wb_valid, io.wb_tag, io.wb_data);
  assign given_a   = io.enq_rdy[0] || new_tag_a == TAG_W'(ZERO_TAG);
  assign given_b   = io.enq_rdy[1] || new_tag_b == TAG_W'(ZERO_TAG);
  assign new_rdy_a = given_a || byp_a;
  assign new_rdy_b = given_b || byp_b;
  assign new_val_a = given_a ? io.enq_val[DATA_W-1:0] : byp_data_a;
  assign new_val_b = given_b ? io.enq_val[2*DATA_W-1:DATA_W] : byp_data_b;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET || FLUSH) begin
      valid <= '0;
      rdy_a <= '0;
      rdy_b <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc[i]) begin
          valid[i] <= 1'b1;
          rdy_a[i] <= new_rdy_a;
          rdy_b[i] <= new_rdy_b;
        end else begin
          if (iss_fire && grant[i]) valid[i] <= 1'b0;
          if (valid[i] && wake_a[i]) rdy_a[i] <= 1'b1;
          if (valid[i] && wake_b[i]) rdy_b[i] <= 1'b1;
        end
      end
    end
  end

  // Operand and payload storage is qualified by valid/rdy, so it carries no reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc[i]) begin
        tag_a[i]   <= new_tag_a;
        tag_b[i]   <= new_tag_b;
        val_a[i]   <= new_val_a;
        val_b[i]   <= new_val_b;
        payload[i] <= io.enq_payload;
      end else begin
        if (valid[i] && !rdy_a[i] && wake_a[i]) val_a[i] <= wake_data_a[i];
        if (valid[i] && !rdy_b[i] && wake_b[i]) val_b[i] <= wake_data_b[i];
      end
    end
  end

  age_select #(.DEPTH(DEPTH)) u_age_select (
    .CLK   (CLK),
    .RESET (RESET),
    .alloc (alloc),
    .req   (req),
    .grant (grant)
  );

  always_comb begin
    io.iss_opa     = '0;
    io.iss_opb     = '0;
    io.iss_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        io.iss_opa     = val_a[i];
        io.iss_opb     = val_b[i];
        io.iss_payload = payload[i];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - self-checking bench for issue_queue (DEPTH=4, NUM_WB=2)
module tb_issue_queue;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       FLUSH;
  logic [2:0] count;
  logic       full, empty;

  issue_queue_if #(.TAG_W(6), .DATA_W(32), .PAYLOAD_W(128), .NUM_WB(2)) io ();

  issue_queue #(.DEPTH(4), .TAG_W(6), .DATA_W(32), .PAYLOAD_W(128), .NUM_WB(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .FLUSH (FLUSH),
    .io    (io),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference: instructions held in age order, oldest at index 0.
  typedef struct {
    bit         ra, rb;
    bit [5:0]   ta, tb;
    bit [31:0]  va, vb;
    bit [127:0] pl;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    bit        ev;
    bit [31:0] a;
    bit        ir;
    int        cnt;
    bit        fl;
    bit        er;
    bit        iv;
    bit [31:0] opa;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit snoop(input bit [5:0] t, output bit [31:0] d);
    d = '0;
    if (t == 6'd0) return 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (io.wb_valid[k] && io.wb_tag[k*6 +: 6] == t) begin
        d = io.wb_data[k*32 +: 32];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int pick();
    for (int i = 0; i < mq.size(); i++) if (mq[i].ra && mq[i].rb) return i;
    return -1;
  endfunction

  task automatic idle();
    io.enq_valid = 1'b0; io.enq_tag = '0; io.enq_rdy = '0; io.enq_val = '0; io.enq_payload = '0;
    io.wb_valid = '0; io.wb_tag = '0; io.wb_data = '0; io.iss_ready = 1'b0; FLUSH = 1'b0;
  endtask

  task automatic set_enq(input bit [5:0] ta, input bit [5:0] tb, input bit [1:0] rdy,
                         input bit [31:0] va, input bit [31:0] vb, input bit [127:0] pl);
    io.enq_valid = 1'b1; io.enq_tag = {tb, ta}; io.enq_rdy = rdy;
    io.enq_val = {vb, va}; io.enq_payload = pl;
  endtask

  task automatic sample_cycle();
    int s;
    bit exp_v;
    @(negedge CLK);
    s = pick();
    exp_v = (s >= 0) && !FLUSH;
    chk("iss_valid", io.iss_valid, exp_v);
    chk("count", count, mq.size());
    chk("full", full, mq.size() == 4);
    chk("empty", empty, mq.size() == 0);
    chk("enq_ready", io.enq_ready, (mq.size() < 4) && !FLUSH);
    chk("iss_no_x", $isunknown({io.iss_opa, io.iss_opb, io.iss_payload}), 1'b0);
    if (exp_v) begin
      chk("iss_opa", io.iss_opa, mq[s].va);
      chk("iss_opb", io.iss_opb, mq[s].vb);
      chk("iss_payload", io.iss_payload, mq[s].pl);
    end
  endtask

  task automatic clock_edge();
    int s, n;
    bit [31:0] d;
    ent_t e;
    @(posedge CLK);
    s = pick();
    n = mq.size();
    if (FLUSH) begin
      mq.delete();
    end else begin
      if (s >= 0 && io.iss_ready) mq.delete(s);
      for (int i = 0; i < mq.size(); i++) begin
        if (!mq[i].ra && snoop(mq[i].ta, d)) begin mq[i].ra = 1'b1; mq[i].va = d; end
        if (!mq[i].rb && snoop(mq[i].tb, d)) begin mq[i].rb = 1'b1; mq[i].vb = d; end
      end
      if (io.enq_valid && n < 4) begin
        e.ta = io.enq_tag[5:0];
        e.tb = io.enq_tag[11:6];
        e.pl = io.enq_payload;
        if (io.enq_rdy[0] || e.ta == 6'd0) begin e.ra = 1'b1; e.va = io.enq_val[31:0]; end
        else begin e.ra = snoop(e.ta, d); e.va = d; end
        if (io.enq_rdy[1] || e.tb == 6'd0) begin e.rb = 1'b1; e.vb = io.enq_val[63:32]; end
        else begin e.rb = snoop(e.tb, d); e.vb = d; end
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic step();
    sample_cycle();
    clock_edge();
  endtask

  initial begin
    RESET = 1'b1;
    idle();
    tbl[0] = '{1, 32'h10, 0, 0, 0, 1, 0, 32'h0};
    tbl[1] = '{1, 32'h11, 0, 1, 0, 1, 1, 32'h10};
    tbl[2] = '{1, 32'h12, 0, 2, 0, 1, 1, 32'h10};
    tbl[3] = '{1, 32'h13, 0, 3, 0, 1, 1, 32'h10};
    tbl[4] = '{1, 32'h14, 0, 4, 1, 0, 1, 32'h10};
    tbl[5] = '{0, 32'h0,  1, 4, 1, 0, 1, 32'h10};
    tbl[6] = '{0, 32'h0,  1, 3, 0, 1, 1, 32'h11};
    tbl[7] = '{0, 32'h0,  1, 2, 0, 1, 1, 32'h12};
    tbl[8] = '{0, 32'h0,  1, 1, 0, 1, 1, 32'h13};
    tbl[9] = '{0, 32'h0,  0, 0, 0, 1, 0, 32'h0};

    #2;
    chk("rst_count", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_iss_valid", io.iss_valid, 1'b0);
    chk("rst_enq_ready", io.enq_ready, 1'b1);
    #10 RESET = 1'b0;
    @(posedge CLK); #1;

    // Fill to full with ready ops, then drain in order.
    for (int r = 0; r < 10; r++) begin
      idle();
      io.iss_ready = tbl[r].ir;
      if (tbl[r].ev) set_enq(6'd0, 6'd0, 2'b11, tbl[r].a, 32'h0, {96'h0, tbl[r].a});
      sample_cycle();
      chk("tbl_count", count, tbl[r].cnt);
      chk("tbl_full", full, tbl[r].fl);
      chk("tbl_empty", empty, tbl[r].cnt == 0);
      chk("tbl_enq_ready", io.enq_ready, tbl[r].er);
      chk("tbl_iss_valid", io.iss_valid, tbl[r].iv);
      if (tbl[r].iv) chk("tbl_iss_opa", io.iss_opa, tbl[r].opa);
      clock_edge();
    end

    // Wakeup from channel 1 becomes issuable the cycle after the edge.
    idle(); set_enq(6'd7, 6'd0, 2'b10, 32'h0, 32'h77, 128'h20); step();
    idle(); io.wb_valid = 2'b10; io.wb_tag = {6'd7, 6'd0}; io.wb_data = {32'hDEADBEEF, 32'h0};
    sample_cycle(); chk("wake_not_early", io.iss_valid, 1'b0); clock_edge();
    idle(); io.iss_ready = 1'b1;
    sample_cycle(); chk("wake_iss_valid", io.iss_valid, 1'b1); chk("wake_opa", io.iss_opa, 32'hDEADBEEF);
    clock_edge();

    // Both channels hit one source: channel 0 data must win.
    idle(); set_enq(6'd12, 6'd0, 2'b10, 32'h0, 32'h1, 128'h22); step();
    idle(); io.wb_valid = 2'b11; io.wb_tag = {6'd12, 6'd12}; io.wb_data = {32'h2222, 32'h1111}; step();
    idle(); io.iss_ready = 1'b1;
    sample_cycle(); chk("lowk_opa", io.iss_opa, 32'h1111); clock_edge();

    // Enqueue bypass on source B.
    idle(); set_enq(6'd0, 6'd9, 2'b01, 32'h5, 32'h0, 128'h21);
    io.wb_valid = 2'b01; io.wb_tag = {6'd0, 6'd9}; io.wb_data = {32'h0, 32'h55}; step();
    idle(); io.iss_ready = 1'b1;
    sample_cycle(); chk("byp_iss_valid", io.iss_valid, 1'b1); chk("byp_opb", io.iss_opb, 32'h55);
    clock_edge();

    // Younger ready op bypasses a waiting older one; once woken, the older goes before later ops.
    idle(); set_enq(6'd3, 6'd0, 2'b10, 32'h0, 32'h1, 128'hA); step();
    idle(); set_enq(6'd0, 6'd0, 2'b11, 32'h2, 32'h2, 128'hB); io.iss_ready = 1'b1; step();
    idle(); io.iss_ready = 1'b1;
    sample_cycle(); chk("young_first", io.iss_payload, 128'hB); clock_edge();
    idle(); set_enq(6'd0, 6'd0, 2'b11, 32'h4, 32'h4, 128'hC); io.iss_ready = 1'b1;
    io.wb_valid = 2'b01; io.wb_tag = {6'd0, 6'd3}; io.wb_data = {32'h0, 32'h33}; step();
    idle(); io.iss_ready = 1'b1;
    sample_cycle(); chk("old_after_wake", io.iss_payload, 128'hA); chk("old_opa", io.iss_opa, 32'h33);
    clock_edge();
    idle(); io.iss_ready = 1'b1;
    sample_cycle(); chk("later_last", io.iss_payload, 128'hC); clock_edge();

    // FLUSH beats enqueue and issue.
    for (int i = 0; i < 3; i++) begin
      idle(); set_enq(6'd0, 6'd0, 2'b11, i, i, 128'h30 + i); step();
    end
    idle(); set_enq(6'd0, 6'd0, 2'b11, 32'h9, 32'h9, 128'h39); io.iss_ready = 1'b1; FLUSH = 1'b1;
    sample_cycle(); chk("flush_no_iss", io.iss_valid, 1'b0); chk("flush_no_enq", io.enq_ready, 1'b0);
    clock_edge();
    idle(); sample_cycle(); chk("flush_count", count, 3'd0); clock_edge();

    // Asynchronous reset mid-cycle drops waiting entries; their tags later do nothing.
    idle(); set_enq(6'd20, 6'd0, 2'b10, 32'h0, 32'h1, 128'h40); step();
    idle(); set_enq(6'd21, 6'd0, 2'b10, 32'h0, 32'h1, 128'h41); step();
    idle();
    #1 RESET = 1'b1;
    #1;
    chk("arst_empty", empty, 1'b1);
    chk("arst_iss_valid", io.iss_valid, 1'b0);
    chk("arst_count", count, 3'd0);
    RESET = 1'b0;
    mq.delete();
    idle(); io.wb_valid = 2'b11; io.wb_tag = {6'd21, 6'd20}; io.wb_data = {32'h1, 32'h2}; io.iss_ready = 1'b1;
    step();
    idle(); io.iss_ready = 1'b1;
    sample_cycle(); chk("arst_no_wake", io.iss_valid, 1'b0); chk("arst_still_empty", count, 3'd0);
    clock_edge();

    // Randomised traffic against the reference queue.
    for (int c = 0; c < 600; c++) begin
      io.enq_valid   = 1'($urandom_range(0, 1));
      io.enq_tag     = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      io.enq_rdy     = 2'($urandom);
      io.enq_val     = {$urandom, $urandom};
      io.enq_payload = {$urandom, $urandom, $urandom, $urandom};
      io.wb_valid    = 2'($urandom);
      io.wb_tag      = {6'($urandom_range(1, 7)), 6'($urandom_range(1, 7))};
      io.wb_data     = {$urandom, $urandom};
      io.iss_ready   = ($urandom_range(0, 9) < 7);
      FLUSH          = ($urandom_range(0, 49) == 0);
      step();
    end

    idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
